keypad_entry_ctrl: RTL

//  Sequencer between the 3x4 keypad scanner and the 4-digit multiplexed FND.

---
 rtl/keypad_pkg.sv | 74 +++++++
 rtl/fnd_scan.sv | 54 +++++
 rtl/keypad_entry_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller: key codes, FSM states,
// decoded key type and the seven-segment font.
package keypad_pkg;

  localparam logic [7:0] KEY_0    = 8'hA0;
  localparam logic [7:0] KEY_1    = 8'h01;
  localparam logic [7:0] KEY_2    = 8'h02;
  localparam logic [7:0] KEY_3    = 8'h04;
  localparam logic [7:0] KEY_4    = 8'h08;
  localparam logic [7:0] KEY_5    = 8'h10;
  localparam logic [7:0] KEY_6    = 8'h20;
  localparam logic [7:0] KEY_7    = 8'h40;
  localparam logic [7:0] KEY_8    = 8'h80;
  localparam logic [7:0] KEY_9    = 8'h90;
  localparam logic [7:0] KEY_STAR = 8'hB0;
  localparam logic [7:0] KEY_HASH = 8'hC0;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  // Out-of-range nibble reused as the "dash" glyph so the scanner needs no extra input.
  localparam logic [3:0] NIB_DASH = 4'hA;

  typedef enum logic [1:0] {StIdle, StEntry, StDone} entry_state_e;

  typedef enum logic [1:0] {KeyNone, KeyDigit, KeyStar, KeyHash} key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [3:0] digit;
  } key_t;

  function automatic key_t key_decode(input logic [7:0] code);
    key_t k;
    k.kind  = KeyDigit;
    k.digit = 4'h0;
    case (code)
      KEY_0:    k.digit = 4'd0;
      KEY_1:    k.digit = 4'd1;
      KEY_2:    k.digit = 4'd2;
      KEY_3:    k.digit = 4'd3;
      KEY_4:    k.digit = 4'd4;
      KEY_5:    k.digit = 4'd5;
      KEY_6:    k.digit = 4'd6;
      KEY_7:    k.digit = 4'd7;
      KEY_8:    k.digit = 4'd8;
      KEY_9:    k.digit = 4'd9;
      KEY_STAR: k.kind  = KeyStar;
      KEY_HASH: k.kind  = KeyHash;
      default:  k.kind  = KeyNone;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] seg_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:     seg = 8'h3f;
      4'd1:     seg = 8'h06;
      4'd2:     seg = 8'h5b;
      4'd3:     seg = 8'h4f;
      4'd4:     seg = 8'h66;
      4'd5:     seg = 8'h6d;
      4'd6:     seg = 8'h7d;
      4'd7:     seg = 8'h07;
      4'd8:     seg = 8'h7f;
      4'd9:     seg = 8'h6f;
      NIB_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_scan.sv
// Multiplexed FND scanner: slot counter, one-hot digit rotation and registered
// segment output for the digit selected by the new slot.
module fnd_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] nibbles_i,
  input  logic [3:0]  blank_i,
  output logic [3:0]  sel_o,
  output logic [7:0]  data_o
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      sel_q, sel_d;
  logic [7:0]      data_q, data_d;
  logic            wrap;

  assign wrap = (cnt_q == CntW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    sel_d  = sel_q;
    data_d = data_q;
    if (wrap) begin
      sel_d  = {sel_q[2:0], sel_q[3]};
      data_d = SEG_BLANK;
      // Segments follow the slot being entered, not the one being left.
      for (int i = 0; i < 4; i++) begin
        if (sel_d[i] && !blank_i[i]) data_d = seg_font(nibbles_i[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sel_q  <= 4'b0001;
      data_q <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign sel_o  = sel_q;
  assign data_o = data_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: key edge detect, decode, 4-digit entry FSM with
// delete/commit, and display mapping onto the FND scanner.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIGITS   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_en,
  input  logic [7:0]  key_data,
  output logic        fnd_en,
  output logic [3:0]  fnd_sel,
  output logic [7:0]  fnd_data,
  output logic [15:0] value_bcd,
  output logic        value_valid,
  output logic [2:0]  digit_cnt
);

  localparam logic [2:0] MaxCnt = 3'(DIGITS);

  entry_state_e state_q, state_d;
  logic [15:0]  buf_q, buf_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [15:0]  value_q, value_d;
  logic         valid_q, valid_d;
  logic         key_en_q;
  logic         fnd_en_q;
  logic         key_edge;
  key_t         key;
  logic [15:0]  nibbles;
  logic [3:0]   blank;

  assign key_edge = key_en & ~key_en_q;
  assign key      = key_decode(key_data);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    if (key_edge) begin
      unique case (state_q)
        StIdle: begin
          if (key.kind == KeyDigit) begin
            buf_d   = {12'h000, key.digit};
            cnt_d   = 3'd1;
            state_d = StEntry;
          end
        end
        StEntry: begin
          case (key.kind)
            KeyDigit: begin
              // A full buffer drops further digits rather than shifting them out.
              if (cnt_q < MaxCnt) begin
                buf_d = {buf_q[11:0], key.digit};
                cnt_d = cnt_q + 3'd1;
              end
            end
            KeyStar: begin
              buf_d = {4'h0, buf_q[15:4]};
              cnt_d = cnt_q - 3'd1;
              if (cnt_q == 3'd1) state_d = StIdle;
            end
            KeyHash: begin
              value_d = buf_q;
              valid_d = 1'b1;
              state_d = StDone;
            end
            default: ;
          endcase
        end
        StDone: begin
          case (key.kind)
            KeyDigit: begin
              buf_d   = {12'h000, key.digit};
              cnt_d   = 3'd1;
              state_d = StEntry;
            end
            KeyStar: begin
              buf_d   = '0;
              cnt_d   = 3'd0;
              state_d = StIdle;
            end
            KeyHash: valid_d = 1'b1;
            default: ;
          endcase
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    nibbles = buf_q;
    blank   = 4'b0000;
    unique case (state_q)
      StIdle: begin
        nibbles = {12'h000, NIB_DASH};
        blank   = 4'b1110;
      end
      StEntry: begin
        for (int i = 0; i < 4; i++) blank[i] = (i >= int'(cnt_q));
      end
      StDone: begin
        // Leading zeros blanked; the units digit always shows.
        nibbles  = value_q;
        blank[3] = (value_q[15:12] == 4'h0);
        blank[2] = (value_q[15:8] == 8'h00);
        blank[1] = (value_q[15:4] == 12'h000);
      end
      default: blank = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      buf_q    <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      key_en_q <= 1'b0;
      fnd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      key_en_q <= key_en;
      fnd_en_q <= 1'b1;
    end
  end

  fnd_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_fnd_scan (
    .clk_i    (clk),
    .rst_ni   (reset),
    .nibbles_i(nibbles),
    .blank_i  (blank),
    .sel_o    (fnd_sel),
    .data_o   (fnd_data)
  );

  assign fnd_en      = fnd_en_q;
  assign value_bcd   = value_q;
  assign value_valid = valid_q;
  assign digit_cnt   = cnt_q;

endmodule
